uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART async transmitter between `NUM_REQ` byte producers. Each producer offers bytes on a valid/ready interface. The arbiter issues one byte at a time to the transmitter via the `tx_start`/`tx_data`/`tx_busy` handshake and can hold the transmitter for one requester until that requester's packet ends. It sits between the acquisition and command-response sources and the transmitter instance.

---
 rtl/uart_arb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and elaboration helpers for the UART transmit arbiter.
// Holds the FSM state encoding, requester-count limits and a clog2 helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic bit num_req_ok(input int n);
    return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first set request strictly
// after last_id (wrapping modulo N) wins.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_id,
  output logic          any,
  output logic [IW-1:0] pick_id,
  output logic [N-1:0]  pick_onehot
);

  localparam int SW = IW + 1;

  logic [SW-1:0] sum;
  logic [IW-1:0] idx;

  always_comb begin
    any         = 1'b0;
    pick_id     = '0;
    pick_onehot = '0;
    sum         = '0;
    idx         = '0;
    // Scan farthest-first so the candidate nearest after last_id is written last.
    for (int k = N; k >= 1; k--) begin
      sum = {1'b0, last_id} + SW'(k);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      idx = sum[IW-1:0];
      if (req[idx]) begin
        any     = 1'b1;
        pick_id = idx;
      end
    end
    pick_onehot[pick_id] = any;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers, with optional packet lock and an idle lock timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int LOCK_TIMEOUT = 1024,
  localparam int IW           = clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 locked
);

  localparam bit TIMEOUT_EN = (LOCK_TIMEOUT > 0);
  localparam int TW         = TIMEOUT_EN ? clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_MAX   = TIMEOUT_EN ? TW'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [IW-1:0] RESET_GRANT = IW'(NUM_REQ - 1);

  if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
  end

  arb_state_t    state_q,    state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q,  tx_data_d;
  logic [IW-1:0] grant_q,    grant_d;
  logic          last_q,     last_d;
  logic          locked_q,   locked_d;
  logic [TW-1:0] timer_q,    timer_d;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_any;
  logic [IW-1:0]      pick_id;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [7:0]         pick_data;
  logic               lock_idle;
  logic               timer_hit;
  logic               timeout_fire;
  logic               accept;

  // While a packet holds the lock only the owner may compete.
  always_comb begin
    eligible = req_valid;
    if (locked_q) begin
      eligible          = '0;
      eligible[grant_q] = req_valid[grant_q];
    end
  end

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req         (eligible),
    .last_id     (grant_q),
    .any         (pick_any),
    .pick_id     (pick_id),
    .pick_onehot (pick_onehot)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_data = pick_data | req_data[8*i +: 8];
      end
    end
  end

  assign lock_idle    = (state_q == IDLE) && locked_q && !req_valid[grant_q];
  assign timer_hit    = (timer_q == TIMER_MAX);
  assign timeout_fire = TIMEOUT_EN && lock_idle && timer_hit;
  assign accept       = (state_q == IDLE) && !tx_busy && pick_any && !timeout_fire;

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    last_d     = last_q;
    locked_d   = locked_q;
    timer_d    = timer_q;
    case (state_q)
      IDLE: begin
        if (timeout_fire) begin
          locked_d = 1'b0;
        end else if (accept) begin
          tx_data_d  = pick_data;
          grant_d    = pick_id;
          last_d     = req_last[pick_id];
          tx_start_d = 1'b1;
          state_d    = START;
        end else if (TIMEOUT_EN && lock_idle) begin
          timer_d = timer_q + 1'b1;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d  = IDLE;
          locked_d = !last_q;
          if (!last_q) begin
            timer_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= RESET_GRANT;
      last_q     <= 1'b0;
      locked_q   <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      locked_q   <= locked_d;
      timer_q    <= timer_d;
    end
  end

  assign req_ready = accept ? pick_onehot : '0;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, a simple
// transmitter model that stays busy for FRAME cycles, and event logs.
module tb_uart_tx_arbiter;

  localparam int FRAME = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        locked;

  int vecCount;
  int errCount;
  int cycleNum;

  logic [7:0] srcData [4][32];
  logic       srcLast [4][32];
  int         srcHead [4];
  int         srcTail [4];

  int  busyCnt;
  bit  extBusy;
  bit  prevBusy;
  bit  prevLocked;

  int readyCyc [$];
  int readyId [$];
  int lockAtReady [$];
  int startCyc [$];
  int startData [$];
  int busyFallCyc;
  int lockFallCyc;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < 4; i++) begin
      if (srcHead[i] < srcTail[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = srcData[i][srcHead[i]];
        req_last[i]       = srcLast[i][srcHead[i]];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    tx_busy = (busyCnt > 0) || extBusy;
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] data, input bit last);
    srcData[id][srcTail[id]] = data;
    srcLast[id][srcTail[id]] = last;
    srcTail[id] = srcTail[id] + 1;
    driveInputs();
  endtask

  task automatic clearLogs();
    readyCyc.delete();
    readyId.delete();
    lockAtReady.delete();
    startCyc.delete();
    startData.delete();
    busyFallCyc = -1;
    lockFallCyc = -1;
  endtask

  // Sample on the falling edge, update sources and the transmitter model just after the rising edge.
  task automatic stepCycle();
    logic [3:0] acc;
    bit         seenStart;
    @(negedge clk);
    acc = req_ready;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        readyCyc.push_back(cycleNum);
        readyId.push_back(i);
        lockAtReady.push_back(int'(locked));
      end
    end
    if (tx_start) begin
      startCyc.push_back(cycleNum);
      startData.push_back(int'(tx_data));
    end
    if (prevBusy && !tx_busy && busyFallCyc < 0) busyFallCyc = cycleNum;
    if (prevLocked && !locked && lockFallCyc < 0) lockFallCyc = cycleNum;
    prevBusy   = tx_busy;
    prevLocked = locked;
    seenStart  = tx_start;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) srcHead[i] = srcHead[i] + 1;
    end
    if (busyCnt > 0) busyCnt = busyCnt - 1;
    if (seenStart) busyCnt = FRAME;
    driveInputs();
    cycleNum++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    extBusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      srcHead[i] = 0;
      srcTail[i] = 0;
    end
    driveInputs();
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  initial begin
    vecCount   = 0;
    errCount   = 0;
    cycleNum   = 0;
    busyCnt    = 0;
    extBusy    = 1'b0;
    prevBusy   = 1'b0;
    prevLocked = 1'b0;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    tx_busy    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      srcHead[i] = 0;
      srcTail[i] = 0;
    end
    clearLogs();

    // Reset values
    doReset();
    checkOutput("rst_req_ready", int'(req_ready), 0);
    checkOutput("rst_tx_start", int'(tx_start), 0);
    checkOutput("rst_tx_data", int'(tx_data), 0);
    checkOutput("rst_grant_id", int'(grant_id), 3);
    checkOutput("rst_locked", int'(locked), 0);

    // Single requester right after reset
    applyStimulus(2, 8'hA5, 1'b1);
    clearLogs();
    repeat (10) stepCycle();
    checkOutput("t1_ready_count", readyCyc.size(), 1);
    checkOutput("t1_ready_id", readyId[0], 2);
    checkOutput("t1_start_count", startCyc.size(), 1);
    checkOutput("t1_start_latency", startCyc[0] - readyCyc[0], 1);
    checkOutput("t1_tx_data", startData[0], 8'hA5);
    checkOutput("t1_grant_id", int'(grant_id), 2);
    checkOutput("t1_locked", int'(locked), 0);

    // Fairness with all four requesters continuously valid
    doReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(i, 8'(((i + 1) << 4) | k), 1'b1);
      end
    end
    clearLogs();
    repeat (60) stepCycle();
    checkOutput("t2_ready_count", readyCyc.size(), 8);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("t2_order_%0d", j), readyId[j], j % 4);
      checkOutput($sformatf("t2_data_%0d", j), startData[j], (((j % 4) + 1) << 4) | (j / 4));
    end
    checkOutput("t2_byte_spacing", readyCyc[1] - readyCyc[0], 7);

    // Packet lock holds out requester 3 until requester 1 finishes
    applyStimulus(1, 8'h10, 1'b0);
    applyStimulus(1, 8'h11, 1'b0);
    applyStimulus(1, 8'h12, 1'b1);
    applyStimulus(3, 8'h33, 1'b1);
    clearLogs();
    repeat (40) stepCycle();
    checkOutput("t3_ready_count", readyCyc.size(), 4);
    checkOutput("t3_id_0", readyId[0], 1);
    checkOutput("t3_id_1", readyId[1], 1);
    checkOutput("t3_id_2", readyId[2], 1);
    checkOutput("t3_id_3", readyId[3], 3);
    checkOutput("t3_data_0", startData[0], 8'h10);
    checkOutput("t3_data_1", startData[1], 8'h11);
    checkOutput("t3_data_2", startData[2], 8'h12);
    checkOutput("t3_data_3", startData[3], 8'h33);
    checkOutput("t3_lock_0", lockAtReady[0], 0);
    checkOutput("t3_lock_1", lockAtReady[1], 1);
    checkOutput("t3_lock_2", lockAtReady[2], 1);
    checkOutput("t3_lock_3", lockAtReady[3], 0);
    checkOutput("t3_contiguous", readyCyc[1] - readyCyc[0], 7);

    // Lock timeout after requester 0 abandons its packet
    doReset();
    applyStimulus(0, 8'h0A, 1'b0);
    applyStimulus(1, 8'h1B, 1'b1);
    clearLogs();
    repeat (45) stepCycle();
    checkOutput("t4_ready_count", readyCyc.size(), 2);
    checkOutput("t4_first_id", readyId[0], 0);
    checkOutput("t4_second_id", readyId[1], 1);
    checkOutput("t4_lock_fall", lockFallCyc - busyFallCyc, 17);
    checkOutput("t4_grant_after", readyCyc[1] - busyFallCyc, 17);
    checkOutput("t4_second_data", startData[1], 8'h1B);
    checkOutput("t4_second_unlocked", lockAtReady[1], 0);

    // Reset while the transmitter is still busy
    doReset();
    applyStimulus(2, 8'h5C, 1'b0);
    clearLogs();
    for (int n = 0; n < 10 && readyCyc.size() < 1; n++) stepCycle();
    checkOutput("t5_first_ready", readyCyc.size(), 1);
    stepCycle();
    stepCycle();
    rst = 1'b1;
    applyStimulus(0, 8'h77, 1'b1);
    stepCycle();
    rst = 1'b0;
    checkOutput("t5_grant_id", int'(grant_id), 3);
    checkOutput("t5_locked", int'(locked), 0);
    checkOutput("t5_tx_start", int'(tx_start), 0);
    repeat (12) stepCycle();
    checkOutput("t5_ready_count", readyCyc.size(), 2);
    checkOutput("t5_second_id", readyId[1], 0);
    checkOutput("t5_wait_busy", readyCyc[1] - busyFallCyc, 0);
    checkOutput("t5_start_count", startCyc.size(), 2);
    checkOutput("t5_start_latency", startCyc[1] - readyCyc[1], 1);
    checkOutput("t5_second_data", startData[1], 8'h77);

    // External busy blocks all arbitration
    extBusy = 1'b1;
    applyStimulus(0, 8'h40, 1'b1);
    applyStimulus(1, 8'h41, 1'b1);
    applyStimulus(2, 8'h42, 1'b1);
    applyStimulus(3, 8'h43, 1'b1);
    clearLogs();
    repeat (50) stepCycle();
    checkOutput("t6_ready_while_busy", readyCyc.size(), 0);
    checkOutput("t6_start_while_busy", startCyc.size(), 0);
    extBusy = 1'b0;
    driveInputs();
    repeat (3) stepCycle();
    checkOutput("t6_ready_count", readyCyc.size(), 1);
    checkOutput("t6_ready_id", readyId[0], 1);
    checkOutput("t6_data", startData[0], 8'h41);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
